// File: rtl/pc_unit.sv
// Fetch-stage program counter with trap/return/call/branch redirect and misalignment trapping.
// Optional return-address stack is compiled in when RAS_EN is defined.
module pc_unit #(
  parameter int unsigned    n            = 32,
  parameter logic [n-1:0]   RESET_VECTOR = '0,
  parameter logic [31:0]    TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned    RAS_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         stall,
  input  logic         br_valid,
  input  logic [n-1:0] br_target,
  input  logic         call_valid,
  input  logic [n-1:0] call_target,
  input  logic [n-1:0] call_ret_addr,
  input  logic         ret_valid,
  input  logic [n-1:0] ret_fallback,
  input  logic         trap_valid,
  output logic [n-1:0] current_pc,
  output logic [n-1:0] next_pc,
  output logic [n-1:0] epc,
  output logic         misalign_err,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_overflow
);

  localparam logic [n-1:0] TRAP_PC = n'(TRAP_VECTOR);
  localparam logic [n-1:0] PC_STEP = n'(4);

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_STALL,
    SEL_BR,
    SEL_CALL,
    SEL_RET,
    SEL_TRAP
  } sel_t;

  sel_t         sel;
  logic [n-1:0] target;
  logic         misalign;
  logic         take_trap;
  logic         do_push;
  logic         do_pop;
  logic         ras_hit;
  logic [n-1:0] ras_top;
  logic [n-1:0] pc_next;

  logic [n-1:0] current_pc_reg;
  logic [n-1:0] epc_reg;
  logic         misalign_err_reg;

  // Single winner per cycle; losing requests have no side effects at all.
  always_comb begin
    sel    = SEL_SEQ;
    target = '0;
    if (trap_valid) begin
      sel = SEL_TRAP;
    end else if (ret_valid) begin
      sel    = SEL_RET;
      target = ras_hit ? ras_top : ret_fallback;
    end else if (call_valid) begin
      sel    = SEL_CALL;
      target = call_target;
    end else if (br_valid) begin
      sel    = SEL_BR;
      target = br_target;
    end else if (stall) begin
      sel = SEL_STALL;
    end
  end

  assign misalign  = (sel inside {SEL_RET, SEL_CALL, SEL_BR}) && (target[1:0] != 2'b00);
  assign take_trap = (sel == SEL_TRAP) || misalign;
  assign do_push   = (sel == SEL_CALL) && !misalign;
  assign do_pop    = (sel == SEL_RET) && ras_hit && !misalign;

  always_comb begin
    pc_next = current_pc_reg + PC_STEP;
    if (take_trap) begin
      pc_next = TRAP_PC;
    end else if (sel == SEL_STALL) begin
      pc_next = current_pc_reg;
    end else if (sel != SEL_SEQ) begin
      pc_next = target;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      current_pc_reg   <= RESET_VECTOR;
      epc_reg          <= '0;
      misalign_err_reg <= 1'b0;
    end else begin
      current_pc_reg   <= pc_next;
      misalign_err_reg <= misalign;
      if (take_trap) begin
        epc_reg <= current_pc_reg;
      end
    end
  end

  assign current_pc   = current_pc_reg;
  assign next_pc      = pc_next;
  assign epc          = epc_reg;
  assign misalign_err = misalign_err_reg;

`ifdef RAS_EN
  localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [n-1:0]     ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_reg;
  logic [PTR_W:0]   ras_count_reg;
  logic             ras_overflow_reg;

  // ras_ptr_reg is the next write slot; once full it also points at the oldest entry.
  assign ras_hit = (ras_count_reg != '0);
  assign ras_top = ras_mem[ras_ptr_reg - PTR_ONE];

  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[ras_ptr_reg] <= call_ret_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ras_ptr_reg      <= '0;
      ras_count_reg    <= '0;
      ras_overflow_reg <= 1'b0;
    end else if (do_push) begin
      ras_ptr_reg <= ras_ptr_reg + PTR_ONE;
      if (ras_count_reg == CNT_FULL) begin
        ras_overflow_reg <= 1'b1;
      end else begin
        ras_count_reg <= ras_count_reg + CNT_ONE;
      end
    end else if (do_pop) begin
      ras_ptr_reg   <= ras_ptr_reg - PTR_ONE;
      ras_count_reg <= ras_count_reg - CNT_ONE;
    end
  end

  assign ras_empty    = (ras_count_reg == '0);
  assign ras_full     = (ras_count_reg == CNT_FULL);
  assign ras_overflow = ras_overflow_reg;
`else
  logic unused_ras;

  assign ras_hit      = 1'b0;
  assign ras_top      = '0;
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
  assign ras_overflow = 1'b0;
  assign unused_ras   = ^{call_ret_addr, do_push, do_pop, RAS_DEPTH[0]};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven scoreboard bench for pc_unit, covering both the RAS_EN and plain builds,
// plus an 8-bit instance for the wrap-around case.
module tb_pc_unit;

  logic        clk;
  logic        resetn;
  logic        stall, br_valid, call_valid, ret_valid, trap_valid;
  logic [31:0] br_target, call_target, call_ret_addr, ret_fallback;
  logic [31:0] current_pc, next_pc, epc;
  logic        misalign_err, ras_empty, ras_full, ras_overflow;

  logic [7:0]  pc8_current, pc8_next, pc8_epc;
  logic        pc8_mis, pc8_empty, pc8_full, pc8_ovf;

  int checks   = 0;
  int failures = 0;

  pc_unit #(.n(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .RAS_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .br_valid(br_valid), .br_target(br_target),
    .call_valid(call_valid), .call_target(call_target), .call_ret_addr(call_ret_addr),
    .ret_valid(ret_valid), .ret_fallback(ret_fallback), .trap_valid(trap_valid),
    .current_pc(current_pc), .next_pc(next_pc), .epc(epc), .misalign_err(misalign_err),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow)
  );

  pc_unit #(.n(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(32'h100), .RAS_DEPTH(4)) dut8 (
    .clk(clk), .resetn(resetn), .stall(1'b0),
    .br_valid(1'b0), .br_target(8'h00),
    .call_valid(1'b0), .call_target(8'h00), .call_ret_addr(8'h00),
    .ret_valid(1'b0), .ret_fallback(8'h00), .trap_valid(1'b0),
    .current_pc(pc8_current), .next_pc(pc8_next), .epc(pc8_epc), .misalign_err(pc8_mis),
    .ras_empty(pc8_empty), .ras_full(pc8_full), .ras_overflow(pc8_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, br;
    logic [31:0] brt;
    logic        call;
    logic [31:0] ct, cra;
    logic        ret;
    logic [31:0] rfb;
    logic        trap;
    logic [31:0] pc, pc_nr, epc;
    logic        mis, emp, full, ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t v(input logic s, input logic b, input logic [31:0] bt,
                             input logic c, input logic [31:0] ct, input logic [31:0] cra,
                             input logic r, input logic [31:0] rfb, input logic t,
                             input logic [31:0] pc, input logic [31:0] pc_nr, input logic [31:0] e,
                             input logic m, input logic em, input logic fu, input logic ov);
    vec_t x;
    x.stall = s; x.br = b; x.brt = bt; x.call = c; x.ct = ct; x.cra = cra;
    x.ret = r; x.rfb = rfb; x.trap = t; x.pc = pc; x.pc_nr = pc_nr; x.epc = e;
    x.mis = m; x.emp = em; x.full = fu; x.ovf = ov;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall = 0; br_valid = 0; call_valid = 0; ret_valid = 0; trap_valid = 0;
    br_target = '0; call_target = '0; call_ret_addr = '0; ret_fallback = '0;
  endtask

  task automatic apply(input int idx, input vec_t x);
    vec_t e;
    logic [31:0] exp_pc;
    logic        exp_emp, exp_full, exp_ovf;
    stall = x.stall; br_valid = x.br; br_target = x.brt;
    call_valid = x.call; call_target = x.ct; call_ret_addr = x.cra;
    ret_valid = x.ret; ret_fallback = x.rfb; trap_valid = x.trap;
    exp_q.push_back(x);
    #1;
`ifdef RAS_EN
    exp_pc = x.pc;
`else
    exp_pc = x.pc_nr;
`endif
    chk("next_pc", next_pc, exp_pc);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
`ifdef RAS_EN
    exp_pc = e.pc; exp_emp = e.emp; exp_full = e.full; exp_ovf = e.ovf;
`else
    exp_pc = e.pc_nr; exp_emp = 1'b1; exp_full = 1'b0; exp_ovf = 1'b0;
`endif
    chk("current_pc", current_pc, exp_pc);
    chk("epc", epc, e.epc);
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
    chk("ras_empty", {31'b0, ras_empty}, {31'b0, exp_emp});
    chk("ras_full", {31'b0, ras_full}, {31'b0, exp_full});
    chk("ras_overflow", {31'b0, ras_overflow}, {31'b0, exp_ovf});
    $display("txn %0d pc=%h epc=%h mis=%b emp=%b full=%b ovf=%b", idx, current_pc, epc,
             misalign_err, ras_empty, ras_full, ras_overflow);
  endtask

  initial begin
    logic [7:0] exp8 [3];
    exp8[0] = 8'hFC; exp8[1] = 8'h00; exp8[2] = 8'h04;

    //         st br brt     ca ct      cra     re rfb     tr pc      pc_nr   epc     mi em fu ov
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  0,32'h0,  0,32'h4,  32'h4,  32'h0,  0,1,0,0));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  0,32'h0,  0,32'h8,  32'h8,  32'h0,  0,1,0,0));
    tbl.push_back(v(1,0,32'h0,  0,32'h0,  32'h0,  0,32'h0,  0,32'h8,  32'h8,  32'h0,  0,1,0,0));
    tbl.push_back(v(1,0,32'h0,  0,32'h0,  32'h0,  0,32'h0,  0,32'h8,  32'h8,  32'h0,  0,1,0,0));
    tbl.push_back(v(1,1,32'h40, 0,32'h0,  32'h0,  0,32'h0,  0,32'h40, 32'h40, 32'h0,  0,1,0,0));
    tbl.push_back(v(0,0,32'h0,  1,32'h100,32'h0C, 0,32'h0,  0,32'h100,32'h100,32'h0,  0,0,0,0));
    tbl.push_back(v(0,0,32'h0,  1,32'h200,32'h104,0,32'h0,  0,32'h200,32'h200,32'h0,  0,0,0,0));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  1,32'h300,0,32'h104,32'h300,32'h0,  0,0,0,0));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  1,32'h300,0,32'h0C, 32'h300,32'h0,  0,1,0,0));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  1,32'h300,0,32'h300,32'h300,32'h0,  0,1,0,0));
    tbl.push_back(v(0,0,32'h0,  1,32'h400,32'h10, 0,32'h0,  0,32'h400,32'h400,32'h0,  0,0,0,0));
    tbl.push_back(v(0,0,32'h0,  1,32'h400,32'h20, 0,32'h0,  0,32'h400,32'h400,32'h0,  0,0,0,0));
    tbl.push_back(v(0,0,32'h0,  1,32'h400,32'h30, 0,32'h0,  0,32'h400,32'h400,32'h0,  0,0,0,0));
    tbl.push_back(v(0,0,32'h0,  1,32'h400,32'h40, 0,32'h0,  0,32'h400,32'h400,32'h0,  0,0,1,0));
    tbl.push_back(v(0,0,32'h0,  1,32'h400,32'h50, 0,32'h0,  0,32'h400,32'h400,32'h0,  0,0,1,1));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  1,32'h600,0,32'h50, 32'h600,32'h0,  0,0,0,1));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  1,32'h600,0,32'h40, 32'h600,32'h0,  0,0,0,1));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  1,32'h600,0,32'h30, 32'h600,32'h0,  0,0,0,1));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  1,32'h600,0,32'h20, 32'h600,32'h0,  0,1,0,1));
    tbl.push_back(v(0,1,32'h24, 0,32'h0,  32'h0,  0,32'h0,  0,32'h24, 32'h24, 32'h0,  0,1,0,1));
    tbl.push_back(v(0,1,32'h42, 0,32'h0,  32'h0,  0,32'h0,  0,32'h100,32'h100,32'h24, 1,1,0,1));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  0,32'h0,  0,32'h104,32'h104,32'h24, 0,1,0,1));
    tbl.push_back(v(0,0,32'h0,  1,32'h202,32'h8,  0,32'h0,  0,32'h100,32'h100,32'h104,1,1,0,1));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  0,32'h0,  0,32'h104,32'h104,32'h104,0,1,0,1));
    tbl.push_back(v(0,0,32'h0,  1,32'h50, 32'h70, 0,32'h0,  0,32'h50, 32'h50, 32'h104,0,0,0,1));
    tbl.push_back(v(0,1,32'h44, 0,32'h0,  32'h0,  1,32'h500,1,32'h100,32'h100,32'h50, 0,0,0,1));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  1,32'h500,0,32'h70, 32'h500,32'h50, 0,1,0,1));
    tbl.push_back(v(0,1,32'h8,  0,32'h0,  32'h0,  0,32'h0,  0,32'h8,  32'h8,  32'h50, 0,1,0,1));
    tbl.push_back(v(0,1,32'h44, 1,32'h90, 32'hA0, 0,32'h0,  0,32'h90, 32'h90, 32'h50, 0,0,0,1));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  1,32'hB0, 0,32'hA0, 32'hB0, 32'h50, 0,1,0,1));
    tbl.push_back(v(0,1,32'hC,  0,32'h0,  32'h0,  0,32'h0,  0,32'hC,  32'hC,  32'h50, 0,1,0,1));
    tbl.push_back(v(1,0,32'h0,  0,32'h0,  32'h0,  0,32'h0,  1,32'h100,32'h100,32'hC,  0,1,0,1));
    tbl.push_back(v(0,0,32'h0,  0,32'h0,  32'h0,  1,32'h302,0,32'h100,32'h100,32'h100,1,1,0,1));
    tbl.push_back(v(1,0,32'h0,  0,32'h0,  32'h0,  0,32'h0,  0,32'h100,32'h100,32'h100,0,1,0,1));

    // Reset state and sequential fetch, including the 8-bit wrap.
    drive_idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", current_pc, 32'h0);
    chk("reset_epc", epc, 32'h0);
    chk("reset_mis", {31'b0, misalign_err}, 32'h0);
    chk("reset_empty", {31'b0, ras_empty}, 32'h1);
    chk("reset_full", {31'b0, ras_full}, 32'h0);
    chk("reset_ovf", {31'b0, ras_overflow}, 32'h0);
    chk("reset_pc8", {24'b0, pc8_current}, 32'hF8);
    resetn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk("seq_pc", current_pc, 32'(4 * k));
      chk("wrap_pc8", {24'b0, pc8_current}, {24'b0, exp8[k-1]});
      $display("txn seq%0d pc=%h pc8=%h", k, current_pc, pc8_current);
    end

    // Asynchronous reset in the middle of a cycle.
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_pc", current_pc, 32'h0);
    chk("async_reset_pc8", {24'b0, pc8_current}, 32'hF8);
    $display("txn async_reset pc=%h pc8=%h", current_pc, pc8_current);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(i, tbl[i]);
    end
    drive_idle();

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Next-generation program counter for the RISC-V fetch stage, generalised in width and reset/trap vectors. It holds the architectural fetch PC and selects the next PC each cycle from trap, return, call, branch, stall or sequential increment. A parametrised return-address stack (RAS) sits inside the block. Misaligned control-transfer targets are detected and converted into a trap redirect.

Parameters:
n, 32, PC/address width in bits (>= 8)
RESET_VECTOR, 0, value loaded into current_pc on reset
TRAP_VECTOR, 32'h0000_0100, target for trap and misalign redirects (truncated to n bits)
RAS_DEPTH, 4, return-address-stack entries (power of 2, >= 2)

Ports:
clk  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
stall  in  1  hold current_pc (sequential path only)
br_valid  in  1  branch/jump redirect request
br_target  in  n  branch/jump target
call_valid  in  1  call redirect: jump and push return address
call_target  in  n  call target
call_ret_addr  in  n  return address pushed on call
ret_valid  in  1  return: pop RAS, jump to popped value
ret_fallback  in  n  return target used when RAS empty
trap_valid  in  1  exception/interrupt redirect
current_pc  out  n  registered fetch PC
next_pc  out  n  combinational value current_pc takes at next edge
epc  out  n  PC captured on trap or misalign
misalign_err  out  1  one-cycle registered pulse: misaligned target trapped
ras_empty  out  1  RAS holds 0 entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_overflow  out  1  sticky: push occurred while full

Behaviour:
- Reset (resetn=0, async): current_pc=RESET_VECTOR, epc=0, misalign_err=0, RAS count=0, pointer=0, ras_overflow=0; ras_empty=1, ras_full=0.
- All state updates on rising clk; next_pc combinational; one-cycle latency from request to current_pc.
- Priority: trap_valid > ret_valid > call_valid > br_valid > stall > sequential. Lower-priority requests in the same cycle are dropped entirely (no RAS side effects).
- trap: next_pc=TRAP_VECTOR; epc<=current_pc; RAS unchanged.
- ret: target = RAS top if not empty (pop: count-1, pointer-1 mod RAS_DEPTH); else ret_fallback (no pointer change).
- call: target=call_target; push call_ret_addr. Full: overwrite oldest entry (circular), count stays RAS_DEPTH, ras_overflow<=1 until reset.
- br: target=br_target.
- Misalign: if the selected ret/call/br target has bits[1:0]!=0: next_pc=TRAP_VECTOR, epc<=current_pc, misalign_err<=1 for one cycle, RAS not modified (no push/pop).
- Redirects (including trap) override stall.
- stall with no redirect: current_pc held.
- Sequential: current_pc+4, modulo 2^n (wraps to 0 from 2^n-4).
- Reset asserted mid-operation clears everything immediately regardless of clk.

Optional Feature:
RAS_EN. Defined: RAS as above. Undefined: no RAS storage; ret always uses ret_fallback, call does no push; ras_empty=1, ras_full=0, ras_overflow=0 constantly; all other behaviour unchanged.

Test Plan:
- Reset/sequential: resetn=0 then 1, RESET_VECTOR=0, 3 idle cycles -> current_pc 0, 4, 8, C; assert resetn=0 mid-cycle -> current_pc=0 immediately.
- Stall vs redirect: at pc=8 stall=1 for 2 cycles -> holds 8; stall=1 with br_valid=1, br_target=40 -> current_pc=40 next cycle.
- Calls/returns (RAS_EN): call 100/ret_addr 0C, call 200/ret_addr 104, ret, ret -> pc 100, 200, 104, 0C; then ret on empty with ret_fallback=300 -> pc=300, ras_empty stays 1.
- Overflow (RAS_DEPTH=4): 5 calls with ret_addr 10,20,30,40,50 -> ras_full=1, ras_overflow=1; 4 rets -> 50,40,30,20; ras_empty=1.
- Misalign: at pc=24, br_target=42 -> pc=TRAP_VECTOR (100), epc=24, misalign_err high exactly one cycle; misaligned call leaves RAS count unchanged.
- Priority/wrap: trap_valid+ret_valid+br_valid same cycle at pc=50 -> pc=100, epc=50, RAS not popped; n=8 at pc=FC idle -> pc=00.
